csi_capture_controller: RTL



---
 rtl/csi_capture_controller.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/csi_capture_controller.sv
// CSI-2 capture controller: arms on request, stores whole frames from one virtual
// channel into a word-addressed frame buffer, and reports completion or failure.

module csi_capture_controller #(
  parameter logic [1:0] VC         = 2'd0,
  parameter int         ADDR_WIDTH = 17,
  parameter int         TIMEOUT    = 1000000
) (
  input  logic                  clock_p,
  input  logic                  reset,
  input  logic [1:0]            virtual_channel,
  input  logic                  interrupt,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  line_start,
  input  logic                  line_end,
  input  logic [31:0]           image_data,
  input  logic                  image_data_enable,
  input  logic                  capture_request,
  input  logic [7:0]            num_frames,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [31:0]           write_data,
  output logic [7:0]            frame_count,
  output logic [15:0]           line_count
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]     WD_ONE  = WD_W'(1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_FRAMING  = 2'd3;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            targetFrames_q, targetFrames_d;
  // One extra bit marks that the all-ones word has already been written.
  logic [ADDR_WIDTH:0]   wrPtr_q, wrPtr_d;
  logic [WD_W-1:0]       watchdog_q, watchdog_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            errorCode_q, errorCode_d;
  logic                  wrEnable_q, wrEnable_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [31:0]           wrData_q, wrData_d;
  logic [7:0]            frameCount_q, frameCount_d;
  logic [15:0]           lineCount_q, lineCount_d;

  logic       match, fs, fe, ls, beat, overflowed, doWrite;
  logic [7:0] frameNext;
  logic       unusedLineEnd;

  assign match         = (virtual_channel == VC);
  assign fs            = interrupt && frame_start && match;
  assign fe            = interrupt && frame_end && match;
  assign ls            = interrupt && line_start && match;
  assign beat          = image_data_enable && match;
  assign overflowed    = wrPtr_q[ADDR_WIDTH];
  assign frameNext     = frameCount_q + 8'd1;
  assign unusedLineEnd = line_end;

  always_comb begin
    state_d        = state_q;
    targetFrames_d = targetFrames_q;
    wrPtr_d        = wrPtr_q;
    watchdog_d     = watchdog_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    errorCode_d    = errorCode_q;
    wrEnable_d     = 1'b0;
    wrAddr_d       = wrAddr_q;
    wrData_d       = wrData_q;
    frameCount_d   = frameCount_q;
    lineCount_d    = lineCount_q;
    doWrite        = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture_request) begin
          errorCode_d = 2'd0;
          if (num_frames != 8'd0) begin
            targetFrames_d = num_frames;
            frameCount_d   = 8'd0;
            wrPtr_d        = '0;
            wrAddr_d       = '0;
            state_d        = ARMED;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ARMED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (fs) begin
          state_d     = CAPTURE;
          lineCount_d = 16'd0;
          watchdog_d  = '0;
        end
      end

      CAPTURE: begin
        // Priority: abort, FS, FE (a same-cycle beat is still stored), beat, LS.
        if (abort) begin
          state_d = IDLE;
        end else if (fs) begin
          error_d     = 1'b1;
          errorCode_d = ERR_FRAMING;
          state_d     = IDLE;
        end else if (fe) begin
          frameCount_d = frameNext;
          watchdog_d   = '0;
          doWrite      = beat && !overflowed;
          if (frameNext == targetFrames_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ARMED;
          end
        end else if (beat && overflowed) begin
          error_d     = 1'b1;
          errorCode_d = ERR_OVERFLOW;
          state_d     = IDLE;
        end else if (beat || ls) begin
          watchdog_d = '0;
          doWrite    = beat;
          if (ls) begin
            lineCount_d = lineCount_q + 16'd1;
          end
        end else if (watchdog_q == WD_LAST) begin
          error_d     = 1'b1;
          errorCode_d = ERR_TIMEOUT;
          state_d     = IDLE;
        end else begin
          watchdog_d = watchdog_q + WD_ONE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The write presents the pre-increment address one cycle after the beat.
    if (doWrite) begin
      wrEnable_d = 1'b1;
      wrAddr_d   = wrPtr_q[ADDR_WIDTH-1:0];
      wrData_d   = image_data;
      wrPtr_d    = wrPtr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock_p) begin
    if (reset) begin
      state_q        <= IDLE;
      targetFrames_q <= 8'd0;
      wrPtr_q        <= '0;
      watchdog_q     <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      errorCode_q    <= 2'd0;
      wrEnable_q     <= 1'b0;
      wrAddr_q       <= '0;
      wrData_q       <= 32'd0;
      frameCount_q   <= 8'd0;
      lineCount_q    <= 16'd0;
    end else begin
      state_q        <= state_d;
      targetFrames_q <= targetFrames_d;
      wrPtr_q        <= wrPtr_d;
      watchdog_q     <= watchdog_d;
      done_q         <= done_d;
      error_q        <= error_d;
      errorCode_q    <= errorCode_d;
      wrEnable_q     <= wrEnable_d;
      wrAddr_q       <= wrAddr_d;
      wrData_q       <= wrData_d;
      frameCount_q   <= frameCount_d;
      lineCount_q    <= lineCount_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign error         = error_q;
  assign error_code    = errorCode_q;
  assign write_enable  = wrEnable_q;
  assign write_address = wrAddr_q;
  assign write_data    = wrData_q;
  assign frame_count   = frameCount_q;
  assign line_count    = lineCount_q;

endmodule
